// File: rtl/cordic_pkg.sv
// Shared definitions for consumers of the cordic result path: word format,
// serializer states and the sign-magnitude to two's complement helper.
package cordic_pkg;

    // Q7.8 sign-magnitude result word produced by the cordic core.
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    // Byte serializer states: IDLE, then one state per emitted byte.
    typedef enum logic [2:0] {
        IDLE,
        B0,
        B1,
        B2,
        B3
    } ser_state_e;

    // Sign-magnitude to two's complement. Negative zero folds to 0x0000 and
    // the most negative magnitude 0xFFFF becomes 0x8001.
    function automatic logic [DATA_W-1:0] sm2tc(input logic [DATA_W-1:0] sm);
        logic [DATA_W-1:0] mag;
        mag = {1'b0, sm[DATA_W-2:0]};
        if (sm[DATA_W-1]) begin
            return DATA_W'(0) - mag;
        end
        return sm;
    endfunction

endpackage

// File: rtl/cordic_result_drain_if.sv
// Handshake bundle between the cordic result producer/byte consumer side and
// the result drain. The slave modport is the drain itself.
interface cordic_result_drain_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic [DATA_W-1:0] res1;
    logic [DATA_W-1:0] res2;
    logic              in_ready;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              clr_ovf;

    modport master (
        output in_valid, res1, res2, out_ready, clr_ovf,
        input  in_ready, out_byte, out_valid, count, overflow
    );

    modport slave (
        input  in_valid, res1, res2, out_ready, clr_ovf,
        output in_ready, out_byte, out_valid, count, overflow
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-bit pointers so full and empty are distinct.
// Push is ignored when full, pop is ignored when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = CW'(wr_ptr_q - rd_ptr_q);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance; the extra MSB toggles on each wrap.
    always_comb begin
        // NOTE: defaults first so every path assigns the outputs and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // Pointer registers, cleared by reset so the FIFO comes up empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write.
    // NOTE: the array is not reset; pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cordic_result_drain.sv
// Buffers cordic result pairs and streams them out MSB-first as bytes:
// res1[15:8], res1[7:0], res2[15:8], res2[7:0]. Optional conversion from
// sign-magnitude to two's complement is applied as a pair leaves the FIFO.
module cordic_result_drain #(
    parameter int DATA_W  = cordic_pkg::DATA_W,
    parameter int DEPTH   = 8,
    parameter bit TC_CONV = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    cordic_result_drain_if.slave  bus
);

    import cordic_pkg::*;

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PAIR_W = 2 * DATA_W;
    localparam int HOLD_W = PAIR_W - 8;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [PAIR_W-1:0] fifo_rdata;
    logic [PAIR_W-1:0] pop_pair;
    logic [CNT_W-1:0]  fifo_count;
    logic              accept;

    ser_state_e        state_q;
    // The leading byte is loaded straight into out_byte_q, so only the three
    // trailing bytes of the pair need holding.
    logic [HOLD_W-1:0] hold_q;
    logic [7:0]        out_byte_q;
    logic              out_valid_q;
    logic              ovf_q, ovf_d;

    sync_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.in_valid),
        .wdata_i ({bus.res1, bus.res2}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A byte leaves when the consumer takes the registered out_valid.
    assign accept = out_valid_q && bus.out_ready;

    // Pop from IDLE, or back-to-back as the last byte of a pair is accepted.
    assign fifo_pop = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == B3) && accept));

    // Optional format conversion on the pair being popped.
    always_comb begin
        pop_pair = fifo_rdata;
        if (TC_CONV) begin
            pop_pair = {sm2tc(fifo_rdata[PAIR_W-1:DATA_W]),
                        sm2tc(fifo_rdata[DATA_W-1:0])};
        end
    end

    // Serializer FSM with registered out_byte/out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (fifo_pop) begin
            state_q     <= B0;
            hold_q      <= pop_pair[HOLD_W-1:0];
            out_byte_q  <= pop_pair[PAIR_W-1 -: 8];
            out_valid_q <= 1'b1;
        end else if (accept) begin
            case (state_q)
                B0: begin
                    state_q    <= B1;
                    out_byte_q <= hold_q[DATA_W +: 8];
                end
                B1: begin
                    state_q    <= B2;
                    out_byte_q <= hold_q[DATA_W-1 -: 8];
                end
                B2: begin
                    state_q    <= B3;
                    out_byte_q <= hold_q[7:0];
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped push sets it and beats a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (bus.clr_ovf)                 ovf_d = 1'b0;
        if (bus.in_valid && fifo_full)   ovf_d = 1'b1;
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.in_ready  = !fifo_full;
    assign bus.count     = fifo_count;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_cordic_result_drain.sv
// Directed bench for cordic_result_drain: one instance passes words through,
// a second converts to two's complement. sel picks which one is driven/observed.
module tb_cordic_result_drain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sel;
    logic        in_valid;
    logic [15:0] res1;
    logic [15:0] res2;
    logic        out_ready;
    logic        clr_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_q[$];

    cordic_result_drain_if #(.DATA_W(16), .DEPTH(8)) if0();
    cordic_result_drain_if #(.DATA_W(16), .DEPTH(8)) if1();

    cordic_result_drain #(.DATA_W(16), .DEPTH(8), .TC_CONV(1'b0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if0.slave)
    );

    cordic_result_drain #(.DATA_W(16), .DEPTH(8), .TC_CONV(1'b1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    assign if0.in_valid  = in_valid && !sel;
    assign if0.res1      = res1;
    assign if0.res2      = res2;
    assign if0.out_ready = out_ready && !sel;
    assign if0.clr_ovf   = clr_ovf && !sel;
    assign if1.in_valid  = in_valid && sel;
    assign if1.res1      = res1;
    assign if1.res2      = res2;
    assign if1.out_ready = out_ready && sel;
    assign if1.clr_ovf   = clr_ovf && sel;

    logic       cur_valid;
    logic       cur_in_ready;
    logic       cur_ovf;
    logic [7:0] cur_byte;
    logic [3:0] cur_count;

    assign cur_valid    = sel ? if1.out_valid : if0.out_valid;
    assign cur_in_ready = sel ? if1.in_ready  : if0.in_ready;
    assign cur_ovf      = sel ? if1.overflow  : if0.overflow;
    assign cur_byte     = sel ? if1.out_byte  : if0.out_byte;
    assign cur_count    = sel ? if1.count     : if0.count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; the pair is captured on the next edge.
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        res1     = a;
        res2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic queue_pair(input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(b[15:8]);
        exp_q.push_back(b[7:0]);
    endtask

    // Consume exp_q. stall=1 drives out_ready 1,0,0,1,... and checks that a
    // stalled byte is held until taken.
    task automatic drain(input bit stall, input int budget);
        bit         prev_stall = 1'b0;
        logic [7:0] prev_byte  = 8'h00;
        int         cyc        = 0;
        int         idx        = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge clk);
            #1;
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (prev_stall) begin
                check("hold_valid", cur_valid, 1);
                check("hold_byte", cur_byte, prev_byte);
            end
            if (cur_valid && out_ready) begin
                check($sformatf("byte%0d", idx), cur_byte, exp_q.pop_front());
                idx++;
            end
            prev_stall = cur_valid && !out_ready;
            prev_byte  = cur_byte;
            cyc++;
        end
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("drain_end_valid", cur_valid, 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        sel       = 1'b0;
        in_valid  = 1'b0;
        res1      = '0;
        res2      = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        check("rst_valid", cur_valid, 0);
        check("rst_byte", cur_byte, 8'h00);
        check("rst_in_ready", cur_in_ready, 1);
        check("rst_count", cur_count, 0);
        check("rst_ovf", cur_ovf, 0);
        sel = 1'b1;
        #1;
        check("rst_valid_tc", cur_valid, 0);
        sel = 1'b0;

        // Pass-through, latency and consecutive bytes.
        out_ready = 1'b1;
        push_pair(16'h1A60, 16'h0E00);
        check("lat_count1", cur_count, 1);
        check("lat_valid0", cur_valid, 0);
        @(posedge clk); #1;
        check("lat_valid1", cur_valid, 1);
        check("lat_count0", cur_count, 0);
        check("pt_b0", cur_byte, 8'h1A);
        @(posedge clk); #1;
        check("pt_b1", cur_byte, 8'h60);
        @(posedge clk); #1;
        check("pt_b2", cur_byte, 8'h0E);
        @(posedge clk); #1;
        check("pt_b3", cur_byte, 8'h00);
        @(posedge clk); #1;
        check("pt_idle", cur_valid, 0);
        out_ready = 1'b0;

        // Two's complement conversion, two pairs back to back.
        sel = 1'b1;
        push_pair(16'h8310, 16'hF994);
        push_pair(16'h8000, 16'h0200);
        queue_pair(16'hFCF0, 16'h866C);
        queue_pair(16'h0000, 16'h0200);
        drain(1'b0, 40);
        sel = 1'b0;

        // Stalled consumer.
        push_pair(16'hDA2D, 16'hD820);
        queue_pair(16'hDA2D, 16'hD820);
        drain(1'b1, 40);

        // Fill past full with consumer stalled.
        for (int k = 0; k < 10; k++) begin
            push_pair({8'(8'h10 + k), 8'(8'h20 + k)}, {8'(8'h30 + k), 8'(8'h40 + k)});
            if (k == 8) begin
                check("full_count", cur_count, 8);
                check("full_in_ready", cur_in_ready, 0);
                check("full_valid", cur_valid, 1);
                check("full_ovf0", cur_ovf, 0);
            end
        end
        check("ovf_set", cur_ovf, 1);
        check("ovf_count", cur_count, 8);
        clr_ovf = 1'b1;
        push_pair(16'hEEEE, 16'hEEEE);
        clr_ovf = 1'b0;
        check("ovf_set_wins", cur_ovf, 1);
        for (int k = 0; k < 9; k++) begin
            queue_pair({8'(8'h10 + k), 8'(8'h20 + k)}, {8'(8'h30 + k), 8'(8'h40 + k)});
        end
        drain(1'b0, 100);
        check("drained_count", cur_count, 0);
        check("ovf_sticky", cur_ovf, 1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        check("ovf_clear", cur_ovf, 0);

        // Reset while in B2 with three pairs queued.
        push_pair(16'h1122, 16'h3344);
        push_pair(16'h5566, 16'h7788);
        push_pair(16'h99AA, 16'hBBCC);
        push_pair(16'hDDEE, 16'hFF01);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2_byte", cur_byte, 8'h33);
        check("b2_count", cur_count, 3);
        reset = 1'b0;
        #1;
        check("arst_valid", cur_valid, 0);
        check("arst_byte", cur_byte, 8'h00);
        check("arst_in_ready", cur_in_ready, 1);
        check("arst_count", cur_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        begin
            int seen = 0;
            out_ready = 1'b1;
            repeat (12) begin
                @(posedge clk); #1;
                if (cur_valid) seen++;
            end
            check("no_stale", seen, 0);
        end
        out_ready = 1'b0;
        push_pair(16'h0102, 16'h0304);
        queue_pair(16'h0102, 16'h0304);
        drain(1'b0, 40);

        // Push coinciding with B3 acceptance while two pairs are queued.
        push_pair(16'hA0A1, 16'hA2A3);
        push_pair(16'hB0B1, 16'hB2B3);
        push_pair(16'hC0C1, 16'hC2C3);
        check("q2_count", cur_count, 2);
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("q2_b3_byte", cur_byte, 8'hA3);
        push_pair(16'hD0D1, 16'hD2D3);
        check("q2_count_same", cur_count, 2);
        check("q2_next_valid", cur_valid, 1);
        check("q2_next_b0", cur_byte, 8'hB0);
        exp_q.push_back(8'hB1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hB3);
        queue_pair(16'hC0C1, 16'hC2C3);
        queue_pair(16'hD0D1, 16'hD2D3);
        drain(1'b0, 40);
        check("q2_final_count", cur_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
